dtw_traceback: RTL and testbench

- Consumer of the systolic-array path output. Captures the per-cell 2-bit predecessor codes emitted by the 6-PE DTW datapath into a local path store.
- After the final cell is written, walks the warping path backwards from (tlen,rlen) to (0,0).
- Emits one (t,r) step per handshake to the downstream result interface.
- Sits directly after the distance-calculation wrapper; the counterpart reader of its o_tindex/o_rindex/o_path writer.

---
 rtl/dtw_traceback.sv | 175 +++++++++++++++++
 tb/tb_dtw_traceback.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dtw_traceback.sv
// DTW traceback: stores per-cell predecessor codes from the PE array, then walks
// the warping path from (tlen,rlen) back to (0,0), emitting one step per handshake.
module dtw_traceback #(
  parameter int IW  = 5,
  parameter int NPE = 6
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              ena,
  input  logic              i_valid,
  input  logic [NPE-1:0]    i_mask,
  input  logic [NPE*IW-1:0] i_tindex,
  input  logic [NPE*IW-1:0] i_rindex,
  input  logic [NPE*2-1:0]  i_path,
  input  logic              i_last,
  input  logic [IW-1:0]     i_tlen,
  input  logic [IW-1:0]     i_rlen,
  output logic              o_busy,
  output logic              o_step_valid,
  input  logic              i_step_ready,
  output logic [IW-1:0]     o_step_t,
  output logic [IW-1:0]     o_step_r,
  output logic              o_step_last,
  output logic [IW:0]       o_plen,
  output logic              o_done,
  output logic              o_err
);

  localparam int DEPTH = 1 << (2 * IW);

  typedef enum logic [1:0] {IDLE, FILL, TRACE, DONE} state_t;

  state_t          state_reg;
  logic [IW-1:0]   cur_t_reg, cur_r_reg;
  logic [IW-1:0]   tlen_reg, rlen_reg;
  logic [IW:0]     plen_reg;
  logic            busy_reg, step_valid_reg, done_reg, err_reg;

  logic [1:0]      mem [DEPTH];
  logic [2*IW-1:0] lane_addr [NPE];
  logic [1:0]      lane_code [NPE];
  logic [NPE-1:0]  lane_we;
  logic            wr_en;

  logic [1:0]      cur_code;
  logic [IW-1:0]   step_t_next, step_r_next;
  logic            at_origin, illegal, bound_hit, step_end;

  // Lane gi lives at the gi-th field counted from the MSB end.
  genvar gi;
  generate
    for (gi = 0; gi < NPE; gi++) begin : g_lane
      assign lane_we[gi]   = i_mask[NPE-1-gi];
      assign lane_addr[gi] = {i_tindex[(NPE-1-gi)*IW +: IW], i_rindex[(NPE-1-gi)*IW +: IW]};
      assign lane_code[gi] = i_path[(NPE-1-gi)*2 +: 2];
    end
  endgenerate

  assign wr_en = ena && i_valid && ((state_reg == IDLE) || (state_reg == FILL));

  // Ascending lane order makes the highest-numbered lane win on an address clash.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int l = 0; l < NPE; l++) begin
        if (lane_we[l]) mem[lane_addr[l]] <= lane_code[l];
      end
    end
  end

  assign cur_code  = mem[{cur_t_reg, cur_r_reg}];
  assign at_origin = (cur_t_reg == '0) && (cur_r_reg == '0);
  assign bound_hit = (plen_reg == ({1'b0, tlen_reg} + {1'b0, rlen_reg}));

  always_comb begin
    step_t_next = cur_t_reg;
    step_r_next = cur_r_reg;
    illegal     = 1'b0;
    if ((cur_t_reg == '0) && (cur_r_reg != '0)) begin
      step_r_next = cur_r_reg - IW'(1);
    end else if ((cur_r_reg == '0) && (cur_t_reg != '0)) begin
      step_t_next = cur_t_reg - IW'(1);
    end else if (!at_origin) begin
      case (cur_code)
        2'b00: begin
          step_t_next = cur_t_reg - IW'(1);
          step_r_next = cur_r_reg - IW'(1);
        end
        2'b01:   step_t_next = cur_t_reg - IW'(1);
        2'b10:   step_r_next = cur_r_reg - IW'(1);
        default: illegal = 1'b1;
      endcase
    end
  end

  assign step_end = at_origin || illegal || bound_hit;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg      <= IDLE;
      cur_t_reg      <= '0;
      cur_r_reg      <= '0;
      tlen_reg       <= '0;
      rlen_reg       <= '0;
      plen_reg       <= '0;
      busy_reg       <= 1'b0;
      step_valid_reg <= 1'b0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
    end else if (!ena) begin
      state_reg      <= IDLE;
      cur_t_reg      <= '0;
      cur_r_reg      <= '0;
      tlen_reg       <= '0;
      rlen_reg       <= '0;
      plen_reg       <= '0;
      busy_reg       <= 1'b0;
      step_valid_reg <= 1'b0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, FILL: begin
          if (i_valid) begin
            busy_reg <= 1'b1;
            if (state_reg == IDLE) begin
              plen_reg <= '0;
              err_reg  <= 1'b0;
            end
            if (i_last) begin
              tlen_reg       <= i_tlen;
              rlen_reg       <= i_rlen;
              cur_t_reg      <= i_tlen;
              cur_r_reg      <= i_rlen;
              step_valid_reg <= 1'b1;
              state_reg      <= TRACE;
            end else begin
              state_reg <= FILL;
            end
          end
        end
        TRACE: begin
          if (step_valid_reg && i_step_ready) begin
            plen_reg <= plen_reg + (IW+1)'(1);
            if (step_end) begin
              step_valid_reg <= 1'b0;
              busy_reg       <= 1'b0;
              done_reg       <= 1'b1;
              err_reg        <= err_reg | illegal;
              state_reg      <= DONE;
            end else begin
              cur_t_reg <= step_t_next;
              cur_r_reg <= step_r_next;
            end
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign o_busy       = busy_reg;
  assign o_step_valid = step_valid_reg;
  assign o_step_t     = step_valid_reg ? cur_t_reg : '0;
  assign o_step_r     = step_valid_reg ? cur_r_reg : '0;
  assign o_step_last  = step_valid_reg && step_end;
  assign o_plen       = plen_reg;
  assign o_done       = done_reg;
  // The flag shows up with the offending step, then stays sticky.
  assign o_err        = err_reg || (step_valid_reg && illegal);

endmodule

// File: tb/tb_dtw_traceback.sv
// Directed bench for dtw_traceback: fills small matrices, traces them and checks
// the emitted step sequence, handshake behaviour, error flag and reset/enable.
module tb_dtw_traceback;
  localparam int IW  = 5;
  localparam int NPE = 6;

  logic              clk = 1'b0;
  logic              nrst, ena, i_valid, i_last, i_step_ready;
  logic [NPE-1:0]    i_mask;
  logic [NPE*IW-1:0] i_tindex, i_rindex;
  logic [NPE*2-1:0]  i_path;
  logic [IW-1:0]     i_tlen, i_rlen;
  logic              o_busy, o_step_valid, o_step_last, o_done, o_err;
  logic [IW-1:0]     o_step_t, o_step_r;
  logic [IW:0]       o_plen;

  int checks = 0;
  int errors = 0;

  logic [IW-1:0]  lt [NPE];
  logic [IW-1:0]  lr [NPE];
  logic [1:0]     lc [NPE];
  logic [NPE-1:0] lmask;

  int obs_v [64], obs_rdy [64], obs_t [64], obs_r [64];
  int obs_last [64], obs_plen [64], obs_done [64], obs_err [64];
  int acc_t [64], acc_r [64], acc_last [64], acc_cyc [64];
  int nacc;

  always #5 clk = ~clk;

  dtw_traceback #(.IW(IW), .NPE(NPE)) dut (
    .clk(clk), .nrst(nrst), .ena(ena), .i_valid(i_valid), .i_mask(i_mask),
    .i_tindex(i_tindex), .i_rindex(i_rindex), .i_path(i_path), .i_last(i_last),
    .i_tlen(i_tlen), .i_rlen(i_rlen), .o_busy(o_busy), .o_step_valid(o_step_valid),
    .i_step_ready(i_step_ready), .o_step_t(o_step_t), .o_step_r(o_step_r),
    .o_step_last(o_step_last), .o_plen(o_plen), .o_done(o_done), .o_err(o_err)
  );

  task automatic clear_lanes();
    lmask = '0;
    for (int l = 0; l < NPE; l++) begin
      lt[l] = '0;
      lr[l] = '0;
      lc[l] = '0;
    end
  endtask

  task automatic set_lane(input int l, input int t, input int r, input logic [1:0] c);
    lt[l] = IW'(t);
    lr[l] = IW'(r);
    lc[l] = c;
    lmask[NPE-1-l] = 1'b1;
  endtask

  // Called at a falling edge; holds the group across one rising edge.
  task automatic send_group(input logic last, input int tl, input int rl);
    for (int l = 0; l < NPE; l++) begin
      i_tindex[(NPE-1-l)*IW +: IW] = lt[l];
      i_rindex[(NPE-1-l)*IW +: IW] = lr[l];
      i_path[(NPE-1-l)*2 +: 2]     = lc[l];
    end
    i_mask  = lmask;
    i_valid = 1'b1;
    i_last  = last;
    i_tlen  = IW'(tl);
    i_rlen  = IW'(rl);
    @(negedge clk);
    i_valid = 1'b0;
    i_last  = 1'b0;
    clear_lanes();
  endtask

  // Records outputs once per falling edge until o_done or the cycle budget runs out.
  task automatic capture(input int max_cyc, input logic [3:0] pat, output int ncyc, output bit to);
    to   = 1'b1;
    ncyc = 0;
    for (int c = 0; c < max_cyc; c++) begin
      i_step_ready = pat[c % 4];
      obs_v[c]    = int'(o_step_valid);
      obs_rdy[c]  = int'(i_step_ready);
      obs_t[c]    = int'(o_step_t);
      obs_r[c]    = int'(o_step_r);
      obs_last[c] = int'(o_step_last);
      obs_plen[c] = int'(o_plen);
      obs_done[c] = int'(o_done);
      obs_err[c]  = int'(o_err);
      ncyc = c + 1;
      if (o_done) begin
        to = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic extract(input int ncyc);
    nacc = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (obs_v[c] != 0 && obs_rdy[c] != 0) begin
        acc_t[nacc] = obs_t[c];
        acc_r[nacc] = obs_r[c];
        acc_last[nacc] = obs_last[c];
        acc_cyc[nacc] = c;
        $display("  step %0d: t=%0d r=%0d last=%0d plen=%0d", nacc, obs_t[c], obs_r[c], obs_last[c], obs_plen[c]);
        nacc++;
      end
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0; ena = 1'b1; i_valid = 1'b0; i_last = 1'b0; i_step_ready = 1'b0;
    i_mask = '0; i_tindex = '0; i_rindex = '0; i_path = '0; i_tlen = '0; i_rlen = '0;
    clear_lanes();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({o_busy, o_step_valid, o_step_last, o_done, o_err} !== 5'b0 || o_plen !== '0) begin
      errors++;
      $display("FAIL reset_outputs busy/valid/last/done/err=%b plen=%0d, need all 0", {o_busy, o_step_valid, o_step_last, o_done, o_err}, o_plen);
    end
    nrst = 1'b1;
  endtask

  task automatic test_diag();
    int ncyc; bit to;
    int et[3] = '{2, 1, 0};
    int er[3] = '{2, 1, 0};
    set_lane(0, 0, 0, 2'b00); set_lane(1, 0, 1, 2'b00); set_lane(2, 0, 2, 2'b00);
    set_lane(3, 1, 0, 2'b00); set_lane(4, 1, 1, 2'b00); set_lane(5, 1, 2, 2'b00);
    send_group(1'b0, 0, 0);
    checks++;
    if (o_busy !== 1'b1 || o_step_valid !== 1'b0) begin
      errors++;
      $display("FAIL diag_fill busy=%0b valid=%0b, need busy=1 valid=0", o_busy, o_step_valid);
    end
    set_lane(0, 2, 0, 2'b00); set_lane(1, 2, 1, 2'b00); set_lane(2, 2, 2, 2'b00);
    send_group(1'b1, 2, 2);
    capture(40, 4'b1111, ncyc, to);
    extract(ncyc);
    checks++;
    if (to || nacc != 3) begin
      errors++;
      $display("FAIL diag_count steps=%0d timeout=%0b, need 3 steps", nacc, to);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (acc_t[k] != et[k] || acc_r[k] != er[k] || acc_last[k] != int'(k == 2)) begin
        errors++;
        $display("FAIL diag_step%0d got (%0d,%0d,last=%0d) need (%0d,%0d,last=%0d)", k, acc_t[k], acc_r[k], acc_last[k], et[k], er[k], int'(k == 2));
      end
    end
    checks++;
    if (obs_plen[ncyc-1] != 3 || acc_cyc[2] + 1 != ncyc - 1) begin
      errors++;
      $display("FAIL diag_done plen=%0d done_cycle=%0d, need plen=3 done_cycle=%0d", obs_plen[ncyc-1], ncyc - 1, acc_cyc[2] + 1);
    end
  endtask

  task automatic test_t_boundary();
    int ncyc; bit to;
    set_lane(0, 3, 0, 2'b11); set_lane(1, 2, 0, 2'b11); set_lane(2, 1, 0, 2'b10);
    set_lane(3, 0, 0, 2'b11);
    send_group(1'b1, 3, 0);
    capture(40, 4'b1111, ncyc, to);
    extract(ncyc);
    checks++;
    if (to || nacc != 4 || obs_plen[ncyc-1] != 4) begin
      errors++;
      $display("FAIL tbound_count steps=%0d plen=%0d timeout=%0b, need 4/4", nacc, obs_plen[ncyc-1], to);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (acc_t[k] != 3 - k || acc_r[k] != 0 || acc_last[k] != int'(k == 3) || obs_err[acc_cyc[k]] != 0) begin
        errors++;
        $display("FAIL tbound_step%0d got (%0d,%0d,last=%0d,err=%0d) need (%0d,0,last=%0d,err=0)", k, acc_t[k], acc_r[k], acc_last[k], obs_err[acc_cyc[k]], 3 - k, int'(k == 3));
      end
    end
  endtask

  task automatic test_mixed();
    int ncyc; bit to;
    int et[6] = '{3, 2, 2, 1, 1, 0};
    int er[6] = '{3, 3, 2, 1, 0, 0};
    // Lanes 0 and 5 both hit (3,3); lane 5's code must be the one stored.
    set_lane(0, 3, 3, 2'b11); set_lane(1, 2, 3, 2'b10); set_lane(2, 2, 2, 2'b00);
    set_lane(3, 1, 1, 2'b10); set_lane(4, 1, 0, 2'b11); set_lane(5, 3, 3, 2'b01);
    send_group(1'b1, 3, 3);
    capture(40, 4'b1111, ncyc, to);
    extract(ncyc);
    checks++;
    if (to || nacc != 6 || obs_plen[ncyc-1] != 6) begin
      errors++;
      $display("FAIL mixed_count steps=%0d plen=%0d timeout=%0b, need 6/6", nacc, obs_plen[ncyc-1], to);
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (acc_t[k] != et[k] || acc_r[k] != er[k] || acc_last[k] != int'(k == 5)) begin
        errors++;
        $display("FAIL mixed_step%0d got (%0d,%0d,last=%0d) need (%0d,%0d,last=%0d)", k, acc_t[k], acc_r[k], acc_last[k], et[k], er[k], int'(k == 5));
      end
    end
  endtask

  task automatic test_backpressure();
    int ncyc; bit to; int cnt;
    int et[5] = '{2, 2, 1, 0, 0};
    int er[5] = '{3, 2, 2, 1, 0};
    set_lane(0, 2, 3, 2'b10); set_lane(1, 2, 2, 2'b01); set_lane(2, 1, 2, 2'b00);
    set_lane(3, 1, 2, 2'b11);
    lmask[NPE-1-3] = 1'b0;
    send_group(1'b1, 2, 3);
    capture(60, 4'b1001, ncyc, to);
    extract(ncyc);
    checks++;
    if (to || nacc != 5 || obs_plen[ncyc-1] != 5) begin
      errors++;
      $display("FAIL bp_count steps=%0d plen=%0d timeout=%0b, need 5/5", nacc, obs_plen[ncyc-1], to);
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (acc_t[k] != et[k] || acc_r[k] != er[k] || acc_last[k] != int'(k == 4)) begin
        errors++;
        $display("FAIL bp_step%0d got (%0d,%0d,last=%0d) need (%0d,%0d,last=%0d)", k, acc_t[k], acc_r[k], acc_last[k], et[k], er[k], int'(k == 4));
      end
    end
    cnt = 0;
    for (int c = 0; c < ncyc - 1; c++) begin
      if (obs_v[c] != 0 && obs_rdy[c] == 0) begin
        checks++;
        if (obs_v[c+1] == 0 || obs_t[c+1] != obs_t[c] || obs_r[c+1] != obs_r[c]) begin
          errors++;
          $display("FAIL bp_hold cycle %0d got (%0d,%0d,v=%0d) need (%0d,%0d,v=1)", c + 1, obs_t[c+1], obs_r[c+1], obs_v[c+1], obs_t[c], obs_r[c]);
        end
      end
      if (obs_v[c] != 0) begin
        checks++;
        if (obs_plen[c] != cnt) begin
          errors++;
          $display("FAIL bp_plen cycle %0d got %0d need %0d", c, obs_plen[c], cnt);
        end
      end
      if (obs_v[c] != 0 && obs_rdy[c] != 0) cnt++;
    end
  endtask

  task automatic test_illegal();
    int ncyc; bit to;
    int et[3] = '{2, 1, 1};
    int er[3] = '{3, 3, 2};
    set_lane(0, 2, 3, 2'b01); set_lane(1, 1, 3, 2'b10); set_lane(2, 1, 2, 2'b11);
    send_group(1'b1, 2, 3);
    capture(40, 4'b1111, ncyc, to);
    extract(ncyc);
    checks++;
    if (to || nacc != 3 || obs_plen[ncyc-1] != 3) begin
      errors++;
      $display("FAIL illegal_count steps=%0d plen=%0d timeout=%0b, need 3/3", nacc, obs_plen[ncyc-1], to);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (acc_t[k] != et[k] || acc_r[k] != er[k] || acc_last[k] != int'(k == 2) || obs_err[acc_cyc[k]] != int'(k == 2)) begin
        errors++;
        $display("FAIL illegal_step%0d got (%0d,%0d,last=%0d,err=%0d) need (%0d,%0d,last=%0d,err=%0d)", k, acc_t[k], acc_r[k], acc_last[k], obs_err[acc_cyc[k]], et[k], er[k], int'(k == 2), int'(k == 2));
      end
    end
    checks++;
    if (obs_err[ncyc-1] != 1 || obs_done[ncyc-1] != 1) begin
      errors++;
      $display("FAIL illegal_done err=%0d done=%0d, need 1/1", obs_err[ncyc-1], obs_done[ncyc-1]);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (o_err !== 1'b1 || o_done !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL illegal_sticky err=%0b done=%0b busy=%0b, need 1/0/0", o_err, o_done, o_busy);
    end
    set_lane(0, 0, 0, 2'b00);
    send_group(1'b0, 0, 0);
    checks++;
    if (o_err !== 1'b0 || o_busy !== 1'b1 || o_plen !== '0) begin
      errors++;
      $display("FAIL illegal_clear err=%0b busy=%0b plen=%0d, need 0/1/0", o_err, o_busy, o_plen);
    end
    send_group(1'b1, 0, 0);
    capture(20, 4'b1111, ncyc, to);
    extract(ncyc);
    checks++;
    if (to || nacc != 1 || acc_t[0] != 0 || acc_r[0] != 0 || acc_last[0] != 1 || obs_plen[ncyc-1] != 1) begin
      errors++;
      $display("FAIL origin_only steps=%0d first=(%0d,%0d,last=%0d) plen=%0d, need 1 step (0,0,last=1) plen=1", nacc, acc_t[0], acc_r[0], acc_last[0], obs_plen[ncyc-1]);
    end
  endtask

  task automatic test_nrst_mid_trace();
    int ncyc; bit to;
    @(negedge clk);
    send_group(1'b1, 4, 0);
    i_step_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (o_step_valid !== 1'b1 || o_step_t !== 5'd3 || o_plen !== 6'd1) begin
      errors++;
      $display("FAIL nrst_pre valid=%0b t=%0d plen=%0d, need 1/3/1", o_step_valid, o_step_t, o_plen);
    end
    nrst = 1'b0;
    #1;
    checks++;
    if ({o_busy, o_step_valid, o_step_last, o_done, o_err} !== 5'b0 || o_plen !== '0 || o_step_t !== '0 || o_step_r !== '0) begin
      errors++;
      $display("FAIL nrst_clear flags=%b plen=%0d t=%0d r=%0d, need all 0", {o_busy, o_step_valid, o_step_last, o_done, o_err}, o_plen, o_step_t, o_step_r);
    end
    @(negedge clk);
    nrst = 1'b1;
    set_lane(0, 1, 1, 2'b00);
    send_group(1'b1, 1, 1);
    capture(20, 4'b1111, ncyc, to);
    extract(ncyc);
    checks++;
    if (to || nacc != 2 || acc_t[0] != 1 || acc_r[0] != 1 || acc_t[1] != 0 || acc_r[1] != 0 || acc_last[1] != 1 || obs_plen[ncyc-1] != 2) begin
      errors++;
      $display("FAIL nrst_retrace steps=%0d (%0d,%0d),(%0d,%0d) last=%0d plen=%0d, need (1,1),(0,0) last=1 plen=2", nacc, acc_t[0], acc_r[0], acc_t[1], acc_r[1], acc_last[1], obs_plen[ncyc-1]);
    end
  endtask

  task automatic test_ena_mid_trace();
    int ncyc; bit to;
    @(negedge clk);
    send_group(1'b1, 3, 0);
    i_step_ready = 1'b1;
    @(negedge clk);
    ena = 1'b0;
    #1;
    checks++;
    if (o_step_valid !== 1'b1 || o_step_t !== 5'd2 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL ena_pre valid=%0b t=%0d busy=%0b, need 1/2/1", o_step_valid, o_step_t, o_busy);
    end
    @(negedge clk);
    checks++;
    if ({o_busy, o_step_valid, o_step_last, o_done, o_err} !== 5'b0 || o_plen !== '0 || o_step_t !== '0) begin
      errors++;
      $display("FAIL ena_clear flags=%b plen=%0d t=%0d, need all 0", {o_busy, o_step_valid, o_step_last, o_done, o_err}, o_plen, o_step_t);
    end
    ena = 1'b1;
    set_lane(0, 0, 2, 2'b11);
    send_group(1'b1, 0, 2);
    capture(20, 4'b1111, ncyc, to);
    extract(ncyc);
    checks++;
    if (to || nacc != 3 || obs_plen[ncyc-1] != 3) begin
      errors++;
      $display("FAIL ena_retrace_count steps=%0d plen=%0d timeout=%0b, need 3/3", nacc, obs_plen[ncyc-1], to);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (acc_t[k] != 0 || acc_r[k] != 2 - k || acc_last[k] != int'(k == 2)) begin
        errors++;
        $display("FAIL ena_retrace_step%0d got (%0d,%0d,last=%0d) need (0,%0d,last=%0d)", k, acc_t[k], acc_r[k], acc_last[k], 2 - k, int'(k == 2));
      end
    end
  endtask

  initial begin
    test_reset();
    test_diag();
    @(negedge clk);
    test_t_boundary();
    @(negedge clk);
    test_mixed();
    @(negedge clk);
    test_backpressure();
    @(negedge clk);
    test_illegal();
    test_nrst_mid_trace();
    test_ena_mid_trace();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
